// File: rtl/serie_paralelo_rx_if.sv
// Link-side bundle for the byte-serial receiver: the serial bit in,
// the recovered byte, its qualifiers and the lock indication out.
//
// Ports (signals):
//   data_in     serial bit, MSB of each byte first
//   data_out    last byte received while locked
//   valid_out   data_out holds a non-comma byte
//   byte_strobe one-cycle pulse when data_out/valid_out update
//   active      link locked
interface serie_paralelo_rx_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    // Serial source side: drives the line, watches the recovered bytes.
    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    // Receiver side.
    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );

endinterface

// File: rtl/serie_paralelo_rx.sv
// Byte-serial receiver: hunts for the comma bit by bit, confirms
// alignment over BC_COUNT aligned commas, then emits one byte per 8 clocks.
//
// Ports:
//   clk_8f  bit clock (8x byte rate), all state on posedge
//   reset_L asynchronous active-low reset
//   link    slave side of serie_paralelo_rx_if
module serie_paralelo_rx #(
    parameter int          BC_COUNT = 4,
    parameter logic [7:0]  COMMA    = 8'hBC
) (
    input  logic                  clk_8f,
    input  logic                  reset_L,
    serie_paralelo_rx_if.slave    link
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam logic [3:0] BC_N = 4'(BC_COUNT);

    state_e     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       active_q, active_d;

    logic [7:0] nxt;
    logic       is_comma;
    logic       byte_done;
    logic [3:0] bc_inc;

    // The byte as it stands once this edge's bit is shifted in.
    assign nxt       = {sr_q[6:0], link.data_in};
    assign is_comma  = (nxt == COMMA);
    assign byte_done = (bit_cnt_q == 3'd7);
    assign bc_inc    = bc_cnt_q + 4'd1;

    // State register and all datapath flops.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= SEARCH;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            bc_cnt_q   <= 4'd0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            bc_cnt_q   <= bc_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH: begin
                if (is_comma) begin
                    if (BC_COUNT == 1) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (byte_done) begin
                    if (!is_comma) begin
                        state_d = SEARCH;
                    end else if (bc_inc == BC_N) begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Counters and registered outputs.
    always_comb begin
        sr_d       = nxt;
        bit_cnt_d  = bit_cnt_q;
        bc_cnt_d   = bc_cnt_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        active_d   = (state_d == ACTIVE);

        unique case (state_q)
            SEARCH: begin
                // A hit here defines the byte phase and is comma #1.
                if (is_comma) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_done) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_inc;
                    end else begin
                        bc_cnt_d = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                // Phase is frozen once locked; commas straddling
                // byte boundaries are simply data bits.
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_done) begin
                    data_out_d = nxt;
                    valid_d    = !is_comma;
                    strobe_d   = 1'b1;
                end
            end
            default: begin
                bit_cnt_d = 3'd0;
                bc_cnt_d  = 4'd0;
            end
        endcase
    end

    assign link.data_out    = data_out_q;
    assign link.valid_out   = valid_q;
    assign link.byte_strobe = strobe_q;
    assign link.active      = active_q;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Directed bench for serie_paralelo_rx: lock, data, broken alignment,
// mid-byte reset and the single-comma lock variant.
module tb_serie_paralelo_rx;

    logic clk_8f  = 1'b0;
    logic reset_L = 1'b0;

    always #5 clk_8f = ~clk_8f;

    serie_paralelo_rx_if if0 ();
    serie_paralelo_rx_if if1 ();

    serie_paralelo_rx #(.BC_COUNT(4), .COMMA(8'hBC)) dut (
        .clk_8f  (clk_8f),
        .reset_L (reset_L),
        .link    (if0.slave)
    );

    serie_paralelo_rx #(.BC_COUNT(1), .COMMA(8'hBC)) dut1 (
        .clk_8f  (clk_8f),
        .reset_L (reset_L),
        .link    (if1.slave)
    );

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic [8:0] exp_q[$];
    logic [7:0] last_data  = 8'h00;
    logic       last_valid = 1'b0;

    function automatic logic [7:0] b8(input logic x);
        return {7'd0, x};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/data"},   if0.data_out,        8'h00);
        check({tag, "/valid"},  b8(if0.valid_out),   8'h00);
        check({tag, "/strobe"}, b8(if0.byte_strobe), 8'h00);
        check({tag, "/active"}, b8(if0.active),      8'h00);
    endtask

    task automatic bit0(input logic b);
        @(negedge clk_8f);
        if0.data_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    // push=1: the byte is expected to be presented at its LSB edge.
    task automatic send_byte(input string tag, input logic [7:0] v,
                             input bit push, input bit act_beg,
                             input bit act_end);
        logic [8:0] e;
        if (push) exp_q.push_back({v, v != 8'hBC});
        for (int i = 7; i >= 0; i--) begin
            bit0(v[i]);
            if (i == 0 && push) begin
                e = exp_q.pop_front();
                check({tag, "/strobe"}, b8(if0.byte_strobe), 8'h01);
                check({tag, "/data"},   if0.data_out,        e[8:1]);
                check({tag, "/valid"},  b8(if0.valid_out),   b8(e[0]));
                last_data  = e[8:1];
                last_valid = e[0];
            end else begin
                check({tag, "/nostrobe"}, b8(if0.byte_strobe), 8'h00);
                check({tag, "/hold"},     if0.data_out,        last_data);
                check({tag, "/holdv"},    b8(if0.valid_out),   b8(last_valid));
            end
            check({tag, "/active"}, b8(if0.active),
                  b8((i == 0) ? act_end : act_beg));
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_8f);
        reset_L     = 1'b0;
        if0.data_in = 1'b0;
        if1.data_in = 1'b0;
        last_data   = 8'h00;
        last_valid  = 1'b0;
        repeat (n) @(negedge clk_8f);
        reset_L = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        if0.data_in = 1'b0;
        if1.data_in = 1'b0;

        // Reset values with the line toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_8f);
            if0.data_in = i[0];
            @(posedge clk_8f);
            #1;
            check_idle("rst");
        end
        check("rst1/active", b8(if1.active), 8'h00);
        @(negedge clk_8f);
        reset_L     = 1'b1;
        if0.data_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bit0(1'b0);
            check("zeros/active", b8(if0.active),      8'h00);
            check("zeros/strobe", b8(if0.byte_strobe), 8'h00);
        end

        // Lock with arbitrary phase.
        bit0(1'b1);
        check("junk/active", b8(if0.active), 8'h00);
        bit0(1'b0);
        check("junk/active", b8(if0.active), 8'h00);
        bit0(1'b1);
        check("junk/active", b8(if0.active), 8'h00);
        send_byte("lock_bc1", 8'hBC, 0, 0, 0);
        send_byte("lock_bc2", 8'hBC, 0, 0, 0);
        send_byte("lock_bc3", 8'hBC, 0, 0, 0);
        send_byte("lock_bc4", 8'hBC, 0, 0, 1);
        send_byte("lock_a5",  8'hA5, 1, 1, 1);

        // Data stream.
        send_byte("d01", 8'h01, 1, 1, 1);
        send_byte("dbc", 8'hBC, 1, 1, 1);
        send_byte("dff", 8'hFF, 1, 1, 1);

        // Reset four bits into a byte.
        bit0(1'b1);
        bit0(1'b1);
        bit0(1'b0);
        bit0(1'b1);
        check("mid/strobe", b8(if0.byte_strobe), 8'h00);
        @(negedge clk_8f);
        reset_L = 1'b0;
        #1;
        check_idle("midrst");
        last_data  = 8'h00;
        last_valid = 1'b0;
        repeat (2) @(negedge clk_8f);
        check_idle("midrst_hold");
        reset_L = 1'b1;
        send_byte("re_bc1", 8'hBC, 0, 0, 0);
        send_byte("re_bc2", 8'hBC, 0, 0, 0);
        send_byte("re_bc3", 8'hBC, 0, 0, 0);
        send_byte("re_bc4", 8'hBC, 0, 0, 1);
        send_byte("re_3c",  8'h3C, 1, 1, 1);

        // Broken alignment: the 0x00 sends it back to the hunt.
        do_reset(2);
        send_byte("brk_bc1", 8'hBC, 0, 0, 0);
        send_byte("brk_bc2", 8'hBC, 0, 0, 0);
        send_byte("brk_bc3", 8'hBC, 0, 0, 0);
        send_byte("brk_00",  8'h00, 0, 0, 0);
        send_byte("brk_bc4", 8'hBC, 0, 0, 0);
        send_byte("brk_bc5", 8'hBC, 0, 0, 0);
        send_byte("brk_bc6", 8'hBC, 0, 0, 0);
        send_byte("brk_bc7", 8'hBC, 0, 0, 1);
        send_byte("brk_77",  8'h77, 1, 1, 1);

        // Single-comma lock variant.
        do_reset(2);
        v = 8'hBC;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_8f);
            if1.data_in = v[i];
            @(posedge clk_8f);
            #1;
            check("bc1_comma/active", b8(if1.active), b8(i == 0));
            check("bc1_comma/strobe", b8(if1.byte_strobe), 8'h00);
            check("bc1_comma/data",   if1.data_out, 8'h00);
        end
        v = 8'h5A;
        exp_q.push_back({v, 1'b1});
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_8f);
            if1.data_in = v[i];
            @(posedge clk_8f);
            #1;
            check("bc1_5a/strobe", b8(if1.byte_strobe), b8(i == 0));
            check("bc1_5a/active", b8(if1.active), 8'h01);
            if (i == 0) begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("bc1_5a/data",  if1.data_out,      e[8:1]);
                check("bc1_5a/valid", b8(if1.valid_out), b8(e[0]));
            end
        end

        check("sb/empty", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serie_paralelo_rx.md
Name: serie_paralelo_rx

Overview:
- Receiver end of the byte-serial link: recovers 8-bit parallel bytes from a 1-bit MSB-first stream clocked at 8x the byte rate.
- Idle bytes on the link are the comma 0xBC.
- Block finds byte alignment by hunting for the comma, then confirms lock after BC_COUNT consecutive aligned commas.
- Once locked, it presents each received byte with a valid flag (comma → not valid). Sits after the serial line, feeding the parallel datapath.

Parameters:
- BC_COUNT, 4, number of consecutive aligned commas (counting the first hit) required to enter ACTIVE; legal range 1..15.
- COMMA, 8'hBC, idle/alignment byte value.

Ports:
- clk_8f  input  1  bit clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  1  serial bit, sampled each clk_8f posedge, MSB of each byte first.
- data_out  output  8  last received byte in ACTIVE; held between byte boundaries.
- valid_out  output  1  1 when data_out holds a non-comma byte received in ACTIVE.
- byte_strobe  output  1  one-cycle pulse on the edge where data_out/valid_out update.
- active  output  1  1 while in ACTIVE (link locked).

Behaviour:
- Reset (reset_L=0, asynchronous):
  - Internal state: shift register sr=0, bit_cnt=0, bc_cnt=0, state=SEARCH.
  - Outputs: data_out=0, valid_out=0, byte_strobe=0, active=0.
- Every posedge, nxt={sr[6:0],data_in}; sr<=nxt.
- States: SEARCH, ALIGN, ACTIVE.
- SEARCH (bit-granular hunt):
  - On every edge, if nxt==COMMA: bit_cnt<=0 and the hit counts as comma #1.
  - If BC_COUNT==1, go directly to ACTIVE (active<=1); otherwise go to ALIGN with bc_cnt<=1.
  - bit_cnt is not used in SEARCH.
- ALIGN:
  - bit_cnt increments mod 8; a byte completes on the edge where bit_cnt==7, and nxt is then the byte.
  - On completion, if nxt==COMMA: bc_cnt<=bc_cnt+1. If bc_cnt+1==BC_COUNT, go to ACTIVE and set active<=1; bc_cnt is then don't-care.
  - On completion, if nxt!=COMMA: go to SEARCH, bc_cnt<=0. The comma check on this same edge is not re-evaluated.
- ACTIVE:
  - bit_cnt keeps running mod 8.
  - On completion: data_out<=nxt, valid_out<=(nxt!=COMMA), byte_strobe<=1.
  - Otherwise byte_strobe<=0, and data_out/valid_out hold.
  - ACTIVE is left only by reset; there is no loss-of-lock detection in this block.
- Transition into ACTIVE: the confirming comma is NOT presented. data_out/valid_out stay at their prior values and byte_strobe=0 on that edge.
- Latency: data_out/valid_out/byte_strobe update on the same posedge that samples the byte's LSB (0 cycles after the last bit).
- byte_strobe is high for exactly 1 of every 8 cycles in ACTIVE, and never outside ACTIVE.
- A comma embedded across byte boundaries in ACTIVE is ignored (no realignment).
- Reset asserted mid-byte or mid-ALIGN: immediate return to the reset values; the partial byte is discarded.

Test Plan:
- Reset values:
  - Stimulus: hold reset_L=0 for 3 cycles with data_in toggling.
  - Required: data_out=0x00, valid_out=0, byte_strobe=0, active=0 throughout.
  - Release reset with data_in=0 for 16 cycles → active stays 0.
- Lock with arbitrary phase:
  - Stimulus: send 3 junk bits (1,0,1), then 4×0xBC, then 0xA5.
  - Required: active rises on the edge sampling the LSB of the 4th 0xBC.
  - 8 cycles later: data_out=0xA5, valid_out=1, byte_strobe pulses once.
- Data stream:
  - Stimulus: after lock, send 0x01, 0xBC, 0xFF.
  - Required: strobes at 8-cycle spacing; (0x01,1), (0xBC,0), (0xFF,1); outputs held between strobes.
- Broken alignment:
  - Stimulus: send 0xBC,0xBC,0xBC,0x00, then 4×0xBC.
  - Required: no active after the 0x00 (back to SEARCH); active rises only at the end of the second run of four commas.
- Reset mid-operation:
  - Stimulus: in ACTIVE, assert reset_L=0 after 4 bits of a byte; release; resend 4×0xBC + 0x3C.
  - Required: outputs return to the reset values immediately; after relock, data_out=0x3C, valid_out=1.
- BC_COUNT=1 variant:
  - Stimulus: single 0xBC then 0x5A.
  - Required: active asserts on the comma's LSB edge; next strobe gives data_out=0x5A, valid_out=1.
